// File: rtl/dds_lut_engine.sv
// dds_lut_engine
// ----------------------------------------------------------------------------
// DDS lookup engine with an integrated phase accumulator, a phase offset and
// a ping-pong pair of sample tables. The CPU writes the shadow bank over an
// Avalon-MM slave while the DDS reads the active bank. Banks swap on a phase
// wrap (or at once while the DDS is disabled), so the output never mixes
// samples from both tables within one period.
//
// Ports
//   clk, reset_n          system clock, asynchronous active-low reset
//   avs_address           MSB=0: shadow table word, MSB=1: register (low 2 bits)
//   avs_write/avs_read    Avalon strobes (no waitrequest)
//   avs_writedata         write data (table uses [DATA_W-1:0])
//   avs_readdata          zero-extended read data
//   avs_readdatavalid     pulses exactly one cycle after an accepted read
//   sample_en             DDS advance strobe
//   dds_data              current sample (holds between valid pulses)
//   dds_valid             sample valid pulse, two cycles after the strobe
//   phase_wrap            accumulator carry, aligned with dds_valid
//   active_bank           bank currently read by the DDS
//
// Handshake: there is no backpressure anywhere. A read is accepted in any
// cycle with avs_read=1 and avs_write=0 and answered with readdatavalid the
// following cycle; a write is accepted in any cycle with avs_write=1 (a write
// wins over a simultaneous read, which then gets no readdatavalid). Every
// cycle with sample_en=1 and enable=1 produces exactly one dds_valid pulse
// two cycles later.
//
// Register map (MSB=1)
//   0 CTRL    bit0 enable (RW), bit1 swap request (W1S) / swap_pending (R)
//   1 FTW     frequency tuning word [ACC_W-1:0]
//   2 OFFSET  phase offset [ACC_W-1:0]
//   3 STATUS  bit0 active_bank, bit1 swap_pending (read-only)
// ----------------------------------------------------------------------------
module dds_lut_engine #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int ACC_W  = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [ADDR_W:0]   avs_address,
    input  logic              avs_write,
    input  logic              avs_read,
    input  logic [31:0]       avs_writedata,
    output logic [31:0]       avs_readdata,
    output logic              avs_readdatavalid,
    input  logic              sample_en,
    output logic [DATA_W-1:0] dds_data,
    output logic              dds_valid,
    output logic              phase_wrap,
    output logic              active_bank
);

    localparam int DEPTH = 1 << ADDR_W;

    // Both banks live in one array; the bank bit is the index MSB.
    logic [DATA_W-1:0] mem [0:2*DEPTH-1];

    // Control / status state
    logic [ACC_W-1:0]  acc;
    logic [ACC_W-1:0]  ftw;
    logic [ACC_W-1:0]  offset;
    logic              enable;
    logic              swap_pending;

    // Stage 0 -> stage 1 pipeline registers
    logic              s0_valid;
    logic              s0_wrap;
    logic              s0_bank;
    logic [ADDR_W-1:0] s0_addr;

    // Bus decode
    logic              is_reg;
    logic [1:0]        reg_sel;
    logic [ADDR_W-1:0] tab_addr;
    logic              rd_accept;
    logic              ctrl_wr;
    logic              tab_wr;
    logic [31:0]       rd_mux;

    // DDS datapath
    logic [ACC_W:0]    acc_sum;
    logic [ACC_W-1:0]  acc_next;
    logic [ACC_W-1:0]  phase;
    logic              carry;
    logic              fire;
    logic              swap_now;
    logic              bank_next;

    assign is_reg    = avs_address[ADDR_W];
    assign reg_sel   = avs_address[1:0];
    assign tab_addr  = avs_address[ADDR_W-1:0];
    assign rd_accept = avs_read & ~avs_write;
    assign ctrl_wr   = avs_write & is_reg & (reg_sel == 2'd0);
    assign tab_wr    = avs_write & ~is_reg;

    always_comb begin
        acc_sum   = {1'b0, acc} + {1'b0, ftw};
        acc_next  = acc_sum[ACC_W-1:0];
        carry     = acc_sum[ACC_W];
        // Offset is applied to the post-step phase so the first sample after
        // enable already includes one FTW step.
        phase     = acc_next + offset;
        fire      = sample_en & enable;
        // A pending swap waits for a wrap while running, and applies on the
        // next edge while stopped (no wrap will ever come then).
        swap_now  = swap_pending & ((fire & carry) | ~enable);
        bank_next = active_bank ^ swap_now;
    end

    // Read mux, evaluated against the bank active in the cycle of the access.
    always_comb begin
        rd_mux = '0;
        if (!is_reg) begin
            rd_mux[DATA_W-1:0] = mem[{~active_bank, tab_addr}];
        end else begin
            case (reg_sel)
                2'd0:    rd_mux[1:0] = {swap_pending, enable};
                2'd1:    rd_mux[ACC_W-1:0] = ftw;
                2'd2:    rd_mux[ACC_W-1:0] = offset;
                default: rd_mux[1:0] = {swap_pending, active_bank};
            endcase
        end
    end

    // CPU table writes always go to the shadow bank as seen before any swap
    // on this same edge. The table is not reset.
    always_ff @(posedge clk) begin
        if (tab_wr) begin
            mem[{~active_bank, tab_addr}] <= avs_writedata[DATA_W-1:0];
        end
    end

    // Registers, accumulator and swap control
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            acc          <= '0;
            ftw          <= '0;
            offset       <= '0;
            enable       <= 1'b0;
            swap_pending <= 1'b0;
            active_bank  <= 1'b0;
        end else begin
            if (!enable) begin
                acc <= '0;
            end else if (fire) begin
                acc <= acc_next;
            end

            if (avs_write && is_reg && reg_sel == 2'd1) ftw    <= avs_writedata[ACC_W-1:0];
            if (avs_write && is_reg && reg_sel == 2'd2) offset <= avs_writedata[ACC_W-1:0];
            if (ctrl_wr) enable <= avs_writedata[0];

            // A request landing on the edge that consumes the pending swap is
            // absorbed by it, so exactly one swap happens.
            if (swap_now) begin
                swap_pending <= 1'b0;
            end else if (ctrl_wr && avs_writedata[1]) begin
                swap_pending <= 1'b1;
            end

            active_bank <= bank_next;
        end
    end

    // DDS pipeline: stage 0 address, stage 1 table read into the output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s0_valid   <= 1'b0;
            s0_wrap    <= 1'b0;
            s0_bank    <= 1'b0;
            s0_addr    <= '0;
            dds_valid  <= 1'b0;
            phase_wrap <= 1'b0;
            dds_data   <= '0;
        end else begin
            s0_valid <= fire;
            if (fire) begin
                s0_addr <= phase[ACC_W-1 -: ADDR_W];
                // A sample that triggers the swap reads the new bank.
                s0_bank <= bank_next;
                s0_wrap <= carry;
            end
            dds_valid  <= s0_valid;
            phase_wrap <= s0_valid & s0_wrap;
            if (s0_valid) begin
                dds_data <= mem[{s0_bank, s0_addr}];
            end
        end
    end

    // Avalon read response
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            avs_readdata      <= '0;
            avs_readdatavalid <= 1'b0;
        end else begin
            avs_readdatavalid <= rd_accept;
            if (rd_accept) begin
                avs_readdata <= rd_mux;
            end
        end
    end

endmodule

// File: tb/tb_dds_lut_engine.sv
module tb_dds_lut_engine;

  localparam int DATA_W = 16;
  localparam int ADDR_W = 10;
  localparam int ACC_W  = 32;
  localparam logic [10:0] REG = 11'h400;
  localparam longint unsigned MASK = 64'hFFFF_FFFF;

  logic              clk;
  logic              reset_n;
  logic [ADDR_W:0]   avs_address;
  logic              avs_write;
  logic              avs_read;
  logic [31:0]       avs_writedata;
  logic [31:0]       avs_readdata;
  logic              avs_readdatavalid;
  logic              sample_en;
  logic [DATA_W-1:0] dds_data;
  logic              dds_valid;
  logic              phase_wrap;
  logic              active_bank;

  dds_lut_engine #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .ACC_W(ACC_W)) dut (
    .clk               (clk),
    .reset_n           (reset_n),
    .avs_address       (avs_address),
    .avs_write         (avs_write),
    .avs_read          (avs_read),
    .avs_writedata     (avs_writedata),
    .avs_readdata      (avs_readdata),
    .avs_readdatavalid (avs_readdatavalid),
    .sample_en         (sample_en),
    .dds_data          (dds_data),
    .dds_valid         (dds_valid),
    .phase_wrap        (phase_wrap),
    .active_bank       (active_bank)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  typedef struct {
    int unsigned bank;
    int unsigned idx;
    bit          wrap;
    int          due;
  } dds_exp_t;

  typedef struct {
    logic [31:0] data;
    int          due;
  } rd_exp_t;

  dds_exp_t        dds_q[$];
  rd_exp_t         exp_q[$];
  int unsigned     tab[2][1024];
  bit              m_en, m_pend, m_bank;
  longint unsigned m_acc, m_ftw, m_off;

  int          cyc;
  int          n_cmp;
  int          n_fail;
  int          wrap_seen;
  logic [15:0] last_data;
  logic [15:0] wrap_data;
  logic [31:0] last_rd;

  function automatic void cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic void model_reset();
    m_en = 0; m_pend = 0; m_bank = 0;
    m_acc = 0; m_ftw = 0; m_off = 0;
    dds_q.delete();
    exp_q.delete();
  endfunction

  // Applies the rules for the clock edge about to occur, using the inputs
  // currently driven and the pre-edge architectural state.
  function automatic void model_step();
    longint unsigned sum, nacc;
    bit carry, fire, swap, ctrl_w;
    bit n_en, n_pend;
    rd_exp_t r;
    dds_exp_t d;
    if (!reset_n) return;
    sum   = m_acc + m_ftw;
    carry = sum[32];
    nacc  = sum & MASK;
    fire  = sample_en && m_en;
    swap  = m_pend && ((fire && carry) || !m_en);
    if (fire) begin
      d.bank = m_bank ^ swap;
      d.idx  = int'(((nacc + m_off) & MASK) >> (ACC_W - ADDR_W));
      d.wrap = carry;
      d.due  = cyc + 2;
      dds_q.push_back(d);
    end
    ctrl_w = avs_write && avs_address[10] && avs_address[1:0] == 2'd0;
    n_en   = ctrl_w ? avs_writedata[0] : m_en;
    n_pend = swap ? 1'b0 : ((ctrl_w && avs_writedata[1]) ? 1'b1 : m_pend);
    if (avs_write) begin
      if (!avs_address[10]) tab[!m_bank][avs_address[9:0]] = avs_writedata[15:0];
      else if (avs_address[1:0] == 2'd1) m_ftw = avs_writedata;
      else if (avs_address[1:0] == 2'd2) m_off = avs_writedata;
    end else if (avs_read) begin
      r.due = cyc + 1;
      if (!avs_address[10]) r.data = tab[!m_bank][avs_address[9:0]];
      else case (avs_address[1:0])
        2'd0: r.data = {30'd0, m_pend, m_en};
        2'd1: r.data = m_acc == m_acc ? 32'(m_ftw) : 32'd0;
        2'd2: r.data = 32'(m_off);
        default: r.data = {30'd0, m_pend, m_bank};
      endcase
      exp_q.push_back(r);
    end
    m_acc  = !m_en ? 0 : (fire ? nacc : m_acc);
    m_en   = n_en;
    m_pend = n_pend;
    m_bank = m_bank ^ swap;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic check();
    dds_exp_t d;
    rd_exp_t r;
    if (dds_q.size() > 0 && dds_q[0].due == cyc) begin
      d = dds_q.pop_front();
      cmp("dds_valid", dds_valid, 1);
      cmp("dds_data", dds_data, tab[d.bank][d.idx]);
      cmp("phase_wrap", phase_wrap, d.wrap);
      last_data = dds_data;
      if (dds_valid && phase_wrap) begin
        wrap_seen++;
        wrap_data = dds_data;
      end
    end else begin
      cmp("dds_valid_idle", dds_valid, 0);
      cmp("phase_wrap_idle", phase_wrap, 0);
    end
    if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
      r = exp_q.pop_front();
      cmp("readdatavalid", avs_readdatavalid, 1);
      cmp("readdata", avs_readdata, r.data);
      last_rd = avs_readdata;
    end else begin
      cmp("readdatavalid_idle", avs_readdatavalid, 0);
    end
    cmp("active_bank", active_bank, m_bank);
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    cyc++;
    check();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic avs_wr(input logic [10:0] addr, input logic [31:0] data);
    avs_address = addr; avs_writedata = data; avs_write = 1'b1;
    tick();
    avs_write = 1'b0;
  endtask

  task automatic avs_rd(input logic [10:0] addr);
    avs_address = addr; avs_read = 1'b1;
    tick();
    avs_read = 1'b0;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [10:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[6];
  int   w0;

  initial begin
    vecs[0] = '{11'h005,  32'h0000_1234, 32'h0000_1234};
    vecs[1] = '{11'h006,  32'hABCD_5678, 32'h0000_5678};
    vecs[2] = '{REG + 1,  32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[3] = '{REG + 2,  32'h8000_0001, 32'h8000_0001};
    vecs[4] = '{REG + 3,  32'hFFFF_FFFF, 32'h0000_0000};
    vecs[5] = '{REG + 0,  32'h0000_0000, 32'h0000_0000};

    cyc = 0; n_cmp = 0; n_fail = 0; wrap_seen = 0;
    last_rd = '0; last_data = '0; wrap_data = '0;
    reset_n = 1'b0; sample_en = 1'b0;
    avs_address = '0; avs_write = 1'b0; avs_read = 1'b0; avs_writedata = '0;
    model_reset();
    idle(3);
    reset_n = 1'b1;
    idle(2);

    // 1: reset state and STATUS read latency
    cmp("reset_dds_data", dds_data, 0);
    avs_rd(REG + 3);
    cmp("status_after_reset", last_rd, 0);
    idle(1);

    // 2: table / register write-readback vectors
    for (int i = 0; i < 6; i++) begin
      avs_wr(vecs[i].addr, vecs[i].wdata);
      avs_rd(vecs[i].addr);
      cmp($sformatf("vec%0d_readback", i), last_rd, vecs[i].exp);
    end
    avs_wr(REG + 0, 32'h2);
    idle(1);
    avs_rd(REG + 3);
    cmp("status_after_idle_swap", last_rd, 32'h1);

    // 3: ramp table in bank 0, swap it in while stopped, run one period
    for (int i = 0; i < 1024; i++) avs_wr(11'(i), 32'(i));
    avs_wr(REG + 0, 32'h2);
    idle(1);
    avs_wr(REG + 1, 32'h0040_0000);
    avs_wr(REG + 2, 32'h0);
    avs_wr(REG + 0, 32'h1);
    w0 = wrap_seen;
    sample_en = 1'b1;
    tick();
    cmp("t3_no_valid_after_1", dds_valid, 0);
    tick();
    cmp("t3_first_valid", dds_valid, 1);
    cmp("t3_first_data", dds_data, 1);
    idle(1030);
    cmp("t3_wrap_count", wrap_seen - w0, 1);

    // 4: refill shadow while running, swap on the next wrap
    for (int i = 0; i < 1024; i++) avs_wr(11'(i), 32'h8000 + 32'(i));
    avs_wr(REG + 0, 32'h3);
    avs_rd(REG + 3);
    cmp("t4_pending", last_rd[1], 1);
    w0 = wrap_seen;
    idle(1100);
    cmp("t4_wrap_count", wrap_seen - w0, 1);
    cmp("t4_wrap_data", wrap_data, 16'h8000);
    cmp("t4_bank", active_bank, 1);

    // FTW=0: constant output, no wraps
    avs_wr(REG + 1, 32'h0);
    idle(4);
    w0 = wrap_seen;
    idle(20);
    cmp("ftw0_no_wrap", wrap_seen - w0, 0);

    // 5: offset of half a turn
    sample_en = 1'b0;
    avs_wr(REG + 0, 32'h0);
    avs_wr(REG + 2, 32'h8000_0000);
    avs_wr(REG + 1, 32'h0040_0000);
    avs_wr(REG + 0, 32'h1);
    sample_en = 1'b1;
    tick();
    sample_en = 1'b0;
    tick();
    cmp("t5_offset_idx513", last_data, 16'h8000 + 16'd513);
    idle(2);

    // Randomized traffic against the model
    for (int i = 0; i < 2500; i++) begin
      int r;
      sample_en = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 99);
      avs_write = 1'b0; avs_read = 1'b0;
      avs_writedata = $urandom;
      if (r < 5) begin
        avs_address = REG + 0;
        avs_writedata = {30'd0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) != 0)};
        avs_write = 1'b1;
      end else if (r < 10) begin
        avs_address = REG + 1; avs_write = 1'b1;
      end else if (r < 13) begin
        avs_address = REG + 2; avs_write = 1'b1;
      end else if (r < 40) begin
        avs_address = 11'($urandom_range(0, 1023)); avs_write = 1'b1;
      end else if (r < 55) begin
        avs_address = 11'($urandom_range(0, 2047)); avs_read = 1'b1;
      end
      tick();
    end
    avs_write = 1'b0; avs_read = 1'b0;

    // 6: reset mid-stream
    avs_wr(REG + 1, 32'h0123_4567);
    avs_wr(REG + 0, 32'h1);
    sample_en = 1'b1;
    idle(5);
    reset_n = 1'b0;
    #1;
    model_reset();
    cmp("rst_dds_valid", dds_valid, 0);
    cmp("rst_dds_data", dds_data, 0);
    cmp("rst_active_bank", active_bank, 0);
    cmp("rst_phase_wrap", phase_wrap, 0);
    cmp("rst_readdatavalid", avs_readdatavalid, 0);
    tick();
    sample_en = 1'b0;
    reset_n = 1'b1;
    idle(5);
    avs_rd(REG + 1);
    cmp("rst_ftw_cleared", last_rd, 0);
    idle(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/dds_lut_engine.md
Name: dds_lut_engine

Overview:
Parametrised successor to the single-table DDS lookup RAM. It adds an integrated phase accumulator, a phase offset and a ping-pong pair of table banks. The CPU writes the shadow bank over an Avalon-MM slave while the DDS reads the active bank. Banks swap glitch-free on phase wrap.
The block sits between the Nios II Avalon fabric and one DDS output channel (AM/FM/waveform path).

Parameters:
DATA_W, 16, table sample width (1..32)
ADDR_W, 10, log2 table depth per bank (depth = 2^ADDR_W)
ACC_W, 32, phase accumulator width (ADDR_W..32)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
avs_address  in  ADDR_W+1  word address; MSB=0 table (shadow bank), MSB=1 registers (low 2 bits select)
avs_write  in  1  write strobe
avs_read  in  1  read strobe
avs_writedata  in  32  write data (table uses [DATA_W-1:0])
avs_readdata  out  32  read data, zero-extended
avs_readdatavalid  out  1  read data valid
sample_en  in  1  DDS advance strobe
dds_data  out  DATA_W  current sample
dds_valid  out  1  sample valid pulse
phase_wrap  out  1  accumulator carry pulse, aligned with dds_valid
active_bank  out  1  bank currently read by DDS

Behaviour:
- Reset (async assert, sync release): acc=0, FTW=0, OFFSET=0, enable=0, swap_pending=0, active_bank=0, all outputs 0. Table contents are undefined after reset.
- Registers (MSB=1), low 2 bits select:
  - 0 CTRL: bit0 enable (RW); bit1 swap request (write 1 sets swap_pending; reads return swap_pending).
  - 1 FTW [ACC_W-1:0].
  - 2 OFFSET [ACC_W-1:0].
  - 3 STATUS: bit0 active_bank, bit1 swap_pending (RO; writes ignored).
- Table access (MSB=0): always targets bank ~active_bank, decoded in the cycle of the access.
- Read latency is fixed at 1: avs_readdatavalid is asserted the cycle after avs_read, readdata is valid with it. There is no waitrequest. Simultaneous read and write is illegal (write wins, no readdatavalid).
- DDS stage 0, on a cycle with sample_en=1 and enable=1:
  - acc <= acc+FTW, modulo 2^ACC_W; carry = overflow.
  - addr_q <= (acc+FTW+OFFSET)[ACC_W-1 -: ADDR_W], where acc is the pre-update value.
  - If carry and swap_pending: active_bank toggles and swap_pending clears at this edge, and addr_q indexes the NEW bank.
- DDS stage 1: synchronous RAM read of (bank_q, addr_q).
- Stage 2: dds_data registered; dds_valid=1 and phase_wrap=carry, both delayed 2 cycles. Latency from sample_en to dds_valid is 2 cycles. The pipeline accepts one strobe per cycle.
- enable=0: acc forced to 0, no new dds_valid. Samples already in flight complete. dds_data holds its last value.
- swap_pending with enable=0: swap applies the cycle after the request write, with no wrap needed.
- A swap request written while already pending is a no-op; exactly one swap occurs.
- FTW/OFFSET writes take effect on the next sample_en edge after the write edge.
- A CPU table write in the same cycle as a swap goes to the pre-swap shadow bank.
- FTW=0 with sample_en: output is constant and phase_wrap never fires.
- Mid-operation reset_n assertion clears the pipeline immediately; no dds_valid appears after release until a new sample_en.

Test Plan:
1. Reset, then read STATUS -> readdata=0, readdatavalid exactly 1 cycle after the read.
2. Write table word 5 = 0x1234, read word 5 -> 0x00001234. Set CTRL.bit1 with enable=0 -> STATUS reads 0x1 (bank 1 active, not pending).
3. Load bank with table[i]=i; FTW=2^22, OFFSET=0, enable=1, sample_en held high -> dds_data sequence 1,2,3,... with first dds_valid 2 cycles after the first strobe. After 1023 valid samples, table wraps to 0 with phase_wrap=1 on the sample reading index 0.
4. Running as in 3, write shadow table[i]=0x8000+i, then request swap mid-cycle -> STATUS.bit1=1 until the wrap. The sample with phase_wrap=1 reads 0x8000; active_bank toggles; earlier samples use the old bank.
5. OFFSET=2^31 with FTW=2^22 -> the first sample indexes 513 (512 offset + 1 step).
6. Assert reset_n low mid-stream for 1 cycle -> dds_valid, dds_data and active_bank are 0 immediately. FTW reads 0 after release.
